frequency_meter: RTL and testbench
==================================

// Module: frequency_meter
// PURPOSE
//  Measures the rate of a slow square wave, such as a divided clock or an external
//  tick, in the system clock domain.
//  - Counts rising edges of signal_in over a fixed gate window of GATE_CYCLES clocks.
//  - Reports the count once per window, with a one-cycle valid strobe.
//  - Sits on the consumer side of the board's clock-divider tick. Used to self-check
//    divider output and to display measured Hz.
// PARAMETERS
//  GATE_CYCLES  50_000_000  window length in clock_in cycles (1 s at 50 MHz); must be >= 2
//  COUNT_WIDTH  32          width of edge counter and freq_out
// PORTS
//  clock_in    in   1            system clock; all logic on posedge
//  reset       in   1            synchronous, active-high reset
//  enable      in   1            high = run back-to-back windows; low = stop/abort
//  signal_in   in   1            asynchronous input to measure
//  freq_out    out  COUNT_WIDTH  rising edges counted in last completed window
//  freq_valid  out  1            one-cycle pulse; freq_out/overflow updated same cycle
//  overflow    out  1            last completed window saturated the counter
//  busy        out  1            high while a window is in progress
// BEHAVIOUR
//  - Reset values: freq_out=0, freq_valid=0, overflow=0, busy=0. State=IDLE.
//    Synchronizer flops=0. Gate and edge counters=0.
//  - Synchronizer:
//    - 2-flop sync (s1->s2) plus history flop prev; these run in every state.
//    - rise = s2 & ~prev.
//    - Pin-to-rise latency is 3 clocks.
//    - A level that is already high when a window starts is not counted.
//  - State machine: IDLE, MEASURE.
//    - IDLE: busy=0. If enable=1, go to MEASURE on that edge, clearing gate_cnt=0 and
//      edge_cnt=0.
//    - MEASURE: busy=1. Each cycle gate_cnt increments; rise increments edge_cnt.
//      - edge_cnt saturates at 2^COUNT_WIDTH-1; a sticky sat flag is set on an
//        attempted increment past max.
//    - Final cycle (gate_cnt==GATE_CYCLES-1):
//      - freq_out <= edge_cnt + rise, saturated. A rise in the final cycle is counted.
//      - overflow <= sat, or saturation caused by that final add.
//      - freq_valid <= 1.
//      - Counters and sat clear.
//      - Stay in MEASURE if enable=1 (next window starts with no dead cycle);
//        else go to IDLE.
//  - Window timing: the first cycle with busy=1 is gate cycle 0. freq_valid is high
//    exactly GATE_CYCLES cycles later, then every GATE_CYCLES cycles while enabled.
//  - enable=0 mid-window (not the final cycle):
//    - Abort to IDLE on the next edge; busy=0.
//    - No freq_valid; freq_out/overflow hold their previous values.
//  - freq_valid is high for exactly one cycle per completed window and never on abort.
//  - freq_out and overflow hold between windows.
//  - Reset mid-window: all outputs return to reset values on the next edge. With
//    enable=1 after release, a fresh window starts (gate cycle 0 one cycle after
//    reset falls).
//  - Counter widths:
//    - gate_cnt is $clog2(GATE_CYCLES) bits.
//    - The edge_cnt add is COUNT_WIDTH+1 bits internally to detect saturation.
// TESTING  (bench params GATE_CYCLES=100, COUNT_WIDTH=8 unless noted)
//  1. enable=1; signal_in toggles every 5 clocks (period 10) -> freq_valid 100 cycles
//     after busy rises; freq_out=10, overflow=0; repeats every 100 cycles.
//  2. signal_in held 1 before and through the window -> freq_out=0. Held 0 -> 0.
//  3. COUNT_WIDTH=4; signal_in toggles every clock (50 rises/window) -> freq_out=15,
//     overflow=1. Next window at period 10 -> freq_out=10, overflow=0.
//  4. After test 1, drop enable at gate cycle 60 -> busy=0 next cycle, no freq_valid,
//     freq_out stays 10.
//  5. Assert reset for 1 cycle at gate cycle 50, enable held 1 -> freq_out=0, busy=0.
//     New window completes 100 cycles after restart with freq_out=10.
//  6. Rising edge timed so rise occurs in gate cycle 99 -> counted in that window,
//     not the next. Single-pulse input -> freq_out=1.

Source files
------------

// File: rtl/frequency_meter.sv
// Counts synchronized rising edges of signal_in over a fixed gate window and
// reports the saturated count once per completed window with a one-cycle strobe.
module frequency_meter #(
    parameter int unsigned GATE_CYCLES = 50_000_000,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clock_in,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   signal_in,
    output logic [COUNT_WIDTH-1:0] freq_out,
    output logic                   freq_valid,
    output logic                   overflow,
    output logic                   busy
);

    localparam int unsigned GATE_WIDTH = $clog2(GATE_CYCLES);
    localparam logic [GATE_WIDTH-1:0] GATE_LAST = GATE_WIDTH'(GATE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    state_t                 state;
    logic                   sync1;
    logic                   sync2;
    logic                   prev;
    logic                   rise;
    logic [GATE_WIDTH-1:0]  gate_cnt;
    logic [COUNT_WIDTH-1:0] edge_cnt;
    logic                   sat;
    logic [COUNT_WIDTH:0]   edge_sum;
    logic                   sum_carry;
    logic [COUNT_WIDTH-1:0] edge_next;

    // History flop runs in every state so a level already high at window start is not a rise
    always_ff @(posedge clock_in) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= signal_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    always_comb begin
        rise      = sync2 & ~prev;
        edge_sum  = {1'b0, edge_cnt} + {{COUNT_WIDTH{1'b0}}, rise};
        sum_carry = edge_sum[COUNT_WIDTH];
        edge_next = sum_carry ? '1 : edge_sum[COUNT_WIDTH-1:0];
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state      <= IDLE;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            sat        <= 1'b0;
            freq_out   <= '0;
            freq_valid <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (enable) begin
                        state    <= MEASURE;
                        busy     <= 1'b1;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        sat      <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (gate_cnt == GATE_LAST) begin
                        // Final cycle completes even if enable dropped; its rise is included
                        freq_out   <= edge_next;
                        overflow   <= sat | sum_carry;
                        freq_valid <= 1'b1;
                        gate_cnt   <= '0;
                        edge_cnt   <= '0;
                        sat        <= 1'b0;
                        if (!enable) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gate_cnt <= gate_cnt + GATE_WIDTH'(1);
                        edge_cnt <= edge_next;
                        sat      <= sat | sum_carry;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frequency_meter.sv
// Scoreboard bench: stimulus pushes expected window results, monitors pop on freq_valid.
module tb_frequency_meter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_a, en_b;
    logic       sig_a, sig_b;
    logic [7:0] fo_a;
    logic [3:0] fo_b;
    logic       fv_a, fv_b, ov_a, ov_b, busy_a, busy_b;

    int cyc = 0;
    int passed = 0;
    int total = 0;
    int mode_a = 0;
    int mode_b = 0;

    typedef struct {
        int cyc;
        int freq;
        int ovf;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    frequency_meter #(.GATE_CYCLES(100), .COUNT_WIDTH(8)) dut_a (
        .clock_in  (clk),
        .reset     (rst),
        .enable    (en_a),
        .signal_in (sig_a),
        .freq_out  (fo_a),
        .freq_valid(fv_a),
        .overflow  (ov_a),
        .busy      (busy_a)
    );

    frequency_meter #(.GATE_CYCLES(100), .COUNT_WIDTH(4)) dut_b (
        .clock_in  (clk),
        .reset     (rst),
        .enable    (en_b),
        .signal_in (sig_b),
        .freq_out  (fo_b),
        .freq_valid(fv_b),
        .overflow  (ov_b),
        .busy      (busy_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name, input longint act, input longint exp);
        total++;
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // One cycle: advance to the falling edge, then update the generated waveforms
    task automatic step();
        @(negedge clk);
        if (mode_a == 1) sig_a = ((cyc / 5) % 2) == 1;
        case (mode_b)
            1: sig_b = ~sig_b;
            2: sig_b = ((cyc / 5) % 2) == 1;
            default: ;
        endcase
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic push_a(input int c, input int f, input int o);
        exp_t e;
        e.cyc = c; e.freq = f; e.ovf = o;
        qa.push_back(e);
    endtask

    task automatic push_b(input int c, input int f, input int o);
        exp_t e;
        e.cyc = c; e.freq = f; e.ovf = o;
        qb.push_back(e);
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (qa.size() > 0 && qa[0].cyc < cyc) begin
            fail_now("a_valid_missing", cyc, qa[0].cyc);
            void'(qa.pop_front());
        end
        if (fv_a === 1'b1) begin
            if (qa.size() == 0) fail_now("a_unexpected_valid", fo_a, -1);
            else begin
                e = qa.pop_front();
                chk("a_valid_cycle", cyc, e.cyc);
                chk("a_freq_out", fo_a, e.freq);
                chk("a_overflow", ov_a, e.ovf);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (qb.size() > 0 && qb[0].cyc < cyc) begin
            fail_now("b_valid_missing", cyc, qb[0].cyc);
            void'(qb.pop_front());
        end
        if (fv_b === 1'b1) begin
            if (qb.size() == 0) fail_now("b_unexpected_valid", fo_b, -1);
            else begin
                e = qb.pop_front();
                chk("b_valid_cycle", cyc, e.cyc);
                chk("b_freq_out", fo_b, e.freq);
                chk("b_overflow", ov_b, e.ovf);
            end
        end
    end

    initial begin : stim
        int c;
        rst = 1'b1; en_a = 1'b0; en_b = 1'b0; sig_a = 1'b0; sig_b = 1'b0;
        repeat (3) step();
        chk("rst_a_freq", fo_a, 0);
        chk("rst_a_valid", fv_a, 0);
        chk("rst_a_ovf", ov_a, 0);
        chk("rst_a_busy", busy_a, 0);
        chk("rst_b_freq", fo_b, 0);
        chk("rst_b_busy", busy_b, 0);
        rst = 1'b0;
        repeat (5) step();

        // Input held low: no edges
        c = cyc;
        chk("idle_busy", busy_a, 0);
        en_a = 1'b1;
        push_a(c + 101, 0, 0);
        step();
        chk("busy_rise", busy_a, 1);
        wait_to(c + 100);
        en_a = 1'b0;  // dropped in the final gate cycle: window still completes
        wait_to(c + 102);
        chk("busy_after_final", busy_a, 0);

        // Input held high before and through the window: no edges
        sig_a = 1'b1;
        repeat (10) step();
        c = cyc;
        en_a = 1'b1;
        push_a(c + 101, 0, 0);
        wait_to(c + 100);
        en_a = 1'b0;
        wait_to(c + 105);

        // Period-10 square wave, back-to-back windows, then abort at gate cycle 60
        sig_a = 1'b0;
        mode_a = 1;
        repeat (20) step();
        c = cyc;
        en_a = 1'b1;
        push_a(c + 101, 10, 0);
        push_a(c + 201, 10, 0);
        push_a(c + 301, 10, 0);
        wait_to(c + 101);
        chk("no_dead_cycle_busy", busy_a, 1);
        wait_to(c + 361);
        chk("busy_before_abort", busy_a, 1);
        en_a = 1'b0;
        step();
        chk("abort_busy", busy_a, 0);
        chk("abort_freq_hold", fo_a, 10);
        chk("abort_ovf_hold", ov_a, 0);
        repeat (120) step();
        chk("freq_hold_idle", fo_a, 10);

        // Reset pulse at gate cycle 50 with enable held high
        while ((cyc % 10) != 0) step();
        c = cyc;
        en_a = 1'b1;
        wait_to(c + 51);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_freq", fo_a, 0);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_valid", fv_a, 0);
        push_a(c + 153, 10, 0);
        step();
        chk("restart_busy", busy_a, 1);
        wait_to(c + 152);
        en_a = 1'b0;
        wait_to(c + 160);

        // Single pulse whose rise lands in gate cycle 99
        mode_a = 0;
        sig_a = 1'b0;
        repeat (20) step();
        c = cyc;
        en_a = 1'b1;
        push_a(c + 101, 1, 0);
        push_a(c + 201, 0, 0);
        wait_to(c + 98);
        sig_a = 1'b1;
        wait_to(c + 101);
        sig_a = 1'b0;
        wait_to(c + 200);
        en_a = 1'b0;
        wait_to(c + 210);

        // 4-bit counter: 50 rises saturate at 15, then period 10 reads 10
        mode_b = 1;
        repeat (20) step();
        c = cyc;
        en_b = 1'b1;
        push_b(c + 101, 15, 1);
        wait_to(c + 100);
        en_b = 1'b0;
        step();
        mode_b = 2;
        repeat (20) step();
        chk("b_ovf_hold", ov_b, 1);
        chk("b_freq_hold", fo_b, 15);
        c = cyc;
        en_b = 1'b1;
        push_b(c + 101, 10, 0);
        wait_to(c + 100);
        en_b = 1'b0;
        repeat (10) step();

        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
